// File: rtl/param_reg_file_if.sv
// Bus bundle for param_reg_file: read ports, write port, reserve port and scoreboard view.
// Enables are qualifiers sampled on every rising edge; there is no ready/backpressure.
interface param_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [DEPTH-1:0]         busy_vec;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/param_reg_file.sv
// Parametrised multi-read register file with write-first registered reads,
// optional hardwired zero register and a per-register busy scoreboard.
module param_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic              clk,
    input logic              rst,
    param_reg_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic              wr_ok;
    logic              rsv_ok;

    // Address 0 swallows writes and reserves when it is the hardwired zero.
    assign wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign rsv_ok = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Reserve is applied after the write clear so a same-cycle reserve wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            if (wr_ok)  busy_q[bus.wr_addr]  <= 1'b0;
            if (rsv_ok) busy_q[bus.rsv_addr] <= 1'b1;
        end
    end

    assign bus.busy_vec = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              wr_hit;
        logic              rsv_hit;
        logic [DATA_W-1:0] data_next;
        logic              busy_next;
        logic [DATA_W-1:0] data_q;
        logic              busy_q_k;

        assign addr    = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign wr_hit  = wr_ok  && (bus.wr_addr  == addr);
        assign rsv_hit = rsv_ok && (bus.rsv_addr == addr);

        // Port sees the value the entry will hold after this edge.
        assign data_next = wr_hit ? bus.wr_data : mem[addr];
        assign busy_next = rsv_hit ? 1'b1 : (wr_hit ? 1'b0 : busy_q[addr]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q   <= '0;
                busy_q_k <= 1'b0;
            end else if (bus.rd_en[k]) begin
                data_q   <= data_next;
                busy_q_k <= busy_next;
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = data_q;
        assign bus.rd_busy[k]                  = busy_q_k;
    end
endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file: directed scenarios, randomized traffic
// against an array model, and a second instance with a different parameter set.
module tb_param_reg_file;
    logic clk;
    logic rst;

    param_reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();
    param_reg_file_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) bus2 ();

    param_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    param_reg_file #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state for the main instance.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    logic [31:0] m_rd   [2];
    bit          m_rb   [2];
    logic [31:0] exp_q  [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = '0;
            m_rb[k] = 1'b0;
        end
    endtask

    // Apply the edge's write, then reserve, then sample the resulting state on enabled ports.
    task automatic model_edge();
        int a;
        if (bus.wr_en && bus.wr_addr != 0) begin
            m_mem[bus.wr_addr]  = bus.wr_data;
            m_busy[bus.wr_addr] = 1'b0;
        end
        if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (bus.rd_en[k]) begin
                a       = int'(bus.rd_addr[k*5 +: 5]);
                m_rd[k] = m_mem[a];
                m_rb[k] = m_busy[a];
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_bv;
        logic [31:0] exp;
        for (int k = 0; k < 2; k++) exp_q.push_back(m_rd[k]);
        for (int k = 0; k < 2; k++) begin
            exp = exp_q.pop_front();
            chk($sformatf("%s rd_data[%0d]", tag, k), 64'(bus.rd_data[k*32 +: 32]), 64'(exp));
            chk($sformatf("%s rd_busy[%0d]", tag, k), 64'(bus.rd_busy[k]), 64'(m_rb[k]));
        end
        for (int i = 0; i < 32; i++) exp_bv[i] = m_busy[i];
        chk($sformatf("%s busy_vec", tag), 64'(bus.busy_vec), 64'(exp_bv));
    endtask

    task automatic idle();
        bus.rd_en    = '0;
        bus.wr_en    = 1'b0;
        bus.rsv_en   = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic en, input logic [4:0] a);
        bus.rd_en[k]         = en;
        bus.rd_addr[k*5 +: 5] = a;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wr_en   = en;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic set_rsv(input logic en, input logic [4:0] a);
        bus.rsv_en   = en;
        bus.rsv_addr = a;
    endtask

    // One clock edge on the main instance, model update, check, back to the driving phase.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r >= 8) return 5'd31;
        return 5'(r);
    endfunction

    initial begin
        rst = 1'b1;
        bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rsv_addr = '0;
        idle();
        bus2.rd_en = '0; bus2.rd_addr = '0; bus2.wr_en = 1'b0; bus2.wr_addr = '0;
        bus2.wr_data = '0; bus2.rsv_en = 1'b0; bus2.rsv_addr = '0;
        model_reset();
        @(negedge clk);

        // Held reset ignores everything; then zero register drops the write.
        set_wr(1'b1, 5'd0, 32'hDEAD_BEEF);
        set_rd(0, 1'b1, 5'd0);
        set_rd(1, 1'b1, 5'd7);
        step("reset_hold");
        rst = 1'b0;
        step("zero_reg");

        idle();
        set_wr(1'b1, 5'd3, 32'hFFFF_FFFE);
        step("wr3");
        idle();
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd3);
        step("rd3_both");

        idle();
        set_wr(1'b1, 5'd31, 32'd1300);
        set_rd(0, 1'b1, 5'd31);
        step("bypass31");

        idle();
        set_rsv(1'b1, 5'd5);
        step("rsv5");
        idle();
        set_rd(1, 1'b1, 5'd5);
        step("rsv5_rd");

        idle();
        set_wr(1'b1, 5'd5, -32'sd2000);
        set_rd(0, 1'b1, 5'd5);
        step("wr5_clear");

        idle();
        set_wr(1'b1, 5'd5, 32'd77);
        set_rsv(1'b1, 5'd5);
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b1, 5'd5);
        step("rsv_wr5");

        idle();
        set_wr(1'b1, 5'd9, 32'h0000_0900);
        set_rsv(1'b1, 5'd12);
        set_rd(1, 1'b1, 5'd12);
        step("wr_rsv_split");

        idle();
        set_rd(0, 1'b1, 5'd3);
        step("hold_load");
        idle();
        set_rd(0, 1'b0, 5'd31);
        step("hold_keep");

        // Reset pulsed between edges clears outputs without a clock.
        idle();
        set_wr(1'b1, 5'd9, 32'h1111_2222);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        #1 rst = 1'b0;
        idle();
        @(negedge clk);
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd9);
        step("after_rst_a");
        set_rd(0, 1'b1, 5'd31);
        set_rd(1, 1'b1, 5'd5);
        step("after_rst_b");

        for (int n = 0; n < 300; n++) begin
            set_wr(1'($urandom_range(0, 1)), pick_addr(), $urandom());
            set_rsv(1'($urandom_range(0, 3) == 0), pick_addr());
            set_rd(0, 1'($urandom_range(0, 3) != 0), pick_addr());
            set_rd(1, 1'($urandom_range(0, 3) != 0), pick_addr());
            step("rand");
        end
        idle();

        // Second parameter set: entry 0 is an ordinary register.
        bus2.wr_en = 1'b1; bus2.wr_addr = 3'd0; bus2.wr_data = 16'h1234;
        @(posedge clk); #1;
        chk("p2 busy_after_wr", 64'(bus2.busy_vec), 64'h0);
        @(negedge clk);
        bus2.wr_en = 1'b0;
        bus2.rd_en = 3'b111;
        bus2.rd_addr = {3'd0, 3'd0, 3'd0};
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("p2 rd0 port%0d", k), 64'(bus2.rd_data[k*16 +: 16]), 64'h1234);
        @(negedge clk);
        bus2.rsv_en = 1'b1; bus2.rsv_addr = 3'd0;
        bus2.wr_en = 1'b1; bus2.wr_addr = 3'd6; bus2.wr_data = 16'hBEEF;
        bus2.rd_en = 3'b101;
        bus2.rd_addr = {3'd6, 3'd6, 3'd0};
        @(posedge clk); #1;
        chk("p2 busy_vec", 64'(bus2.busy_vec), 64'h01);
        chk("p2 port0 busy", 64'(bus2.rd_busy), 64'b001);
        chk("p2 port0 data", 64'(bus2.rd_data[15:0]), 64'h1234);
        chk("p2 port1 hold", 64'(bus2.rd_data[31:16]), 64'h1234);
        chk("p2 port2 bypass", 64'(bus2.rd_data[47:32]), 64'hBEEF);
        @(negedge clk);
        bus2.rsv_en = 1'b0; bus2.wr_en = 1'b0; bus2.rd_en = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout checks %0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
